// File: rtl/fb_pkg.sv
// Shared types and sizing helpers for the frame-buffer write path.
// Provides the sequencer state enum, default screen size and width helpers.
package fb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AWAIT,
    DRAW,
    NEXT,
    DONE
  } seq_state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  function automatic int src_w(input int max_src);
    return (max_src < 1) ? 1 : $clog2(max_src + 1);
  endfunction

  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/fb_addr_clip.sv
// Clips a pixel against the screen and linearises its address (comb only).
// Ports: x, y (32b), transparent in; write_ok, addr (y*SCREEN_W+x) out.
module fb_addr_clip
  import fb_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W   = addr_w(DEF_SCREEN_W, DEF_SCREEN_H)
) (
  input  logic [31:0]       x,
  input  logic [31:0]       y,
  input  logic              transparent,
  output logic              write_ok,
  output logic [ADDR_W-1:0] addr
);

  logic              in_range;
  logic [ADDR_W-1:0] x_t;
  logic [ADDR_W-1:0] y_t;

  // Full 32-bit unsigned compare: negative coords wrap huge and drop.
  assign in_range = (x < 32'(SCREEN_W)) && (y < 32'(SCREEN_H));
  assign write_ok = in_range && !transparent;

  // Truncation is safe only because in_range gates the store.
  assign x_t  = x[ADDR_W-1:0];
  assign y_t  = y[ADDR_W-1:0];
  assign addr = x_t + y_t * ADDR_W'(SCREEN_W);

endmodule

// File: rtl/fb_write_sequencer.sv
// Grants draw sources once per frame and writes their pixels to the back bank.
// Ports: clk/reset/frame; source handshake; mem_*; banks; round_busy, overrun
// (plus timeout when WRITE_TIMEOUT_EN is defined).
module fb_write_sequencer
  import fb_pkg::*;
#(
  parameter int MAX_WRITE_SOURCE = 1,
  parameter int COLOR_DEPTH      = 9,
  parameter int SCREEN_W         = DEF_SCREEN_W,
  parameter int SCREEN_H         = DEF_SCREEN_H
`ifdef WRITE_TIMEOUT_EN
  ,
  parameter int AWAIT_TIMEOUT    = 1024
`endif
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                frame,
  output logic [src_w(MAX_WRITE_SOURCE)-1:0]  write_source_sel,
  output logic                                write_awaited,
  input  logic                                write_active,
  input  logic [31:0]                         write_x_addr,
  input  logic [31:0]                         write_y_addr,
  input  logic [COLOR_DEPTH-1:0]              write_color_data,
  input  logic                                write_transparent,
  output logic                                mem_we,
  output logic [addr_w(SCREEN_W,SCREEN_H)-1:0] mem_addr,
  output logic [COLOR_DEPTH-1:0]              mem_wdata,
  output logic                                mem_bank,
  output logic                                display_bank,
  output logic                                round_busy,
  output logic                                overrun
`ifdef WRITE_TIMEOUT_EN
  ,
  output logic                                timeout
`endif
);

  localparam int SRC_W  = src_w(MAX_WRITE_SOURCE);
  localparam int ADDR_W = addr_w(SCREEN_W, SCREEN_H);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(MAX_WRITE_SOURCE);

  seq_state_t        state;
  seq_state_t        state_nx;
  logic              start;
  logic              swap;
  logic              take;
  logic              skip;
  logic              clip_ok;
  logic [ADDR_W-1:0] clip_addr;

  fb_addr_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ADDR_W   (ADDR_W)
  ) u_clip (
    .x           (write_x_addr),
    .y           (write_y_addr),
    .transparent (write_transparent),
    .write_ok    (clip_ok),
    .addr        (clip_addr)
  );

  assign start = frame && (state == IDLE || state == DONE);
  // First frame after reset must not swap: nothing was drawn yet.
  assign swap  = frame && (state == DONE);
  assign take  = write_awaited && write_active && clip_ok;

`ifdef WRITE_TIMEOUT_EN
  localparam int CNT_W = $clog2(AWAIT_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counter is zero on the grant cycle, so skip fires on AWAIT cycle T.
  assign skip = (state == AWAIT) && !write_active &&
                (wait_cnt == CNT_W'(AWAIT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= (state == AWAIT) ? wait_cnt + 1'b1 : '0;
      timeout  <= skip;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (frame) state_nx = AWAIT;
      AWAIT: begin
        if (write_active) state_nx = DRAW;
        else if (skip)    state_nx = NEXT;
      end
      DRAW: if (!write_active) state_nx = NEXT;
      NEXT: begin
        if (write_source_sel < LAST_SRC) state_nx = AWAIT;
        else                             state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    write_awaited = (state == AWAIT) || (state == DRAW);
    round_busy    = (state == AWAIT) || (state == DRAW) ||
                    (state == NEXT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_source_sel <= '0;
      display_bank     <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      overrun          <= 1'b0;
    end else begin
      if (start) begin
        write_source_sel <= '0;
      end else if (state == NEXT && write_source_sel < LAST_SRC) begin
        write_source_sel <= write_source_sel + 1'b1;
      end
      if (swap) display_bank <= ~display_bank;
      mem_we <= take;
      if (take) begin
        mem_addr  <= clip_addr;
        mem_wdata <= write_color_data;
      end
      overrun <= frame && round_busy;
    end
  end

  assign mem_bank = ~display_bank;

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Self-checking bench for fb_write_sequencer: scoreboarded pixel writes.
// Build with WRITE_TIMEOUT_EN to also cover the await timeout.
module tb_fb_write_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame;
  logic [0:0]  write_source_sel;
  logic        write_awaited;
  logic        write_active;
  logic [31:0] write_x_addr;
  logic [31:0] write_y_addr;
  logic [8:0]  write_color_data;
  logic        write_transparent;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [8:0]  mem_wdata;
  logic        mem_bank;
  logic        display_bank;
  logic        round_busy;
  logic        overrun;
`ifdef WRITE_TIMEOUT_EN
  logic        timeout;
`endif

  typedef struct {
    logic [18:0] addr;
    logic [8:0]  data;
    int          due;
  } wr_t;

  wr_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fb_write_sequencer #(
    .MAX_WRITE_SOURCE (1),
    .COLOR_DEPTH      (9),
    .SCREEN_W         (640),
    .SCREEN_H         (480)
`ifdef WRITE_TIMEOUT_EN
    ,
    .AWAIT_TIMEOUT    (8)
`endif
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .frame             (frame),
    .write_source_sel  (write_source_sel),
    .write_awaited     (write_awaited),
    .write_active      (write_active),
    .write_x_addr      (write_x_addr),
    .write_y_addr      (write_y_addr),
    .write_color_data  (write_color_data),
    .write_transparent (write_transparent),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_bank          (mem_bank),
    .display_bank      (display_bank),
    .round_busy        (round_busy),
    .overrun           (overrun)
`ifdef WRITE_TIMEOUT_EN
    ,
    .timeout           (timeout)
`endif
  );

  // Write monitor: every mem_we must match the oldest expected write.
  always @(negedge clk) begin
    n_cmp++;
    if (mem_bank !== ~display_bank) begin
      n_bad++;
      $display("FAIL bank_pair: mem_bank=%b display_bank=%b",
               mem_bank, display_bank);
    end
    if (mem_we === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h cyc=%0d",
                 mem_addr, mem_wdata, cyc);
      end else begin
        wr_t e;
        e = q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.due) begin
          n_bad++;
          $display("FAIL write: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [31:0] x, input logic [31:0] y,
                    input logic [8:0] c, input logic t);
    wr_t   e;
    logic [31:0] a;
    write_active      = 1'b1;
    write_x_addr      = x;
    write_y_addr      = y;
    write_color_data  = c;
    write_transparent = t;
    if (x < 32'd640 && y < 32'd480 && !t) begin
      a      = y * 32'd640 + x;
      e.addr = a[18:0];
      e.data = c;
      e.due  = cyc + 1;
      q.push_back(e);
    end
    tick();
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic end_source();
    write_active = 1'b0;
    tick();
    n_cmp++;
    if (write_awaited !== 1'b0 || round_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL next_state: awaited=%b busy=%b want 0 1",
               write_awaited, round_busy);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (display_bank !== 1'b0 || mem_bank !== 1'b1 ||
        write_awaited !== 1'b0 || write_source_sel !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== 19'd0 || mem_wdata !== 9'd0 ||
        round_busy !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: db=%b mb=%b aw=%b sel=%b we=%b busy=%b ov=%b",
               display_bank, mem_bank, write_awaited, write_source_sel,
               mem_we, round_busy, overrun);
    end
`ifdef WRITE_TIMEOUT_EN
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_timeout: got %b want 0", timeout);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_frame();
    frame_pulse();
    n_cmp++;
    if (display_bank !== 1'b0 || mem_bank !== 1'b1 ||
        write_source_sel !== 1'b0 || write_awaited !== 1'b1 ||
        round_busy !== 1'b1 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL first_frame: db=%b mb=%b sel=%b aw=%b busy=%b ov=%b",
               display_bank, mem_bank, write_source_sel, write_awaited,
               round_busy, overrun);
    end
  endtask

  task automatic test_pixels();
    px(32'd0, 32'd0, 9'h1FF, 1'b0);
    px(32'd639, 32'd0, 9'h1FF, 1'b0);
    px(32'd0, 32'd1, 9'h1FF, 1'b0);
    px(32'd5, 32'd7, 9'h0A5, 1'b0);
  endtask

  task automatic test_drops();
    px(32'd640, 32'd5, 9'h011, 1'b0);
    px(32'd3, 32'd480, 9'h022, 1'b0);
    px(32'hFFFF_FFFF, 32'd0, 9'h033, 1'b0);
    px(32'd10, 32'd10, 9'h044, 1'b1);
    px(32'd638, 32'd479, 9'h155, 1'b0);
  endtask

  task automatic test_round_end();
    end_source();
    n_cmp++;
    if (write_source_sel !== 1'b1 || write_awaited !== 1'b1) begin
      n_bad++;
      $display("FAIL sel_step: sel=%b aw=%b want 1 1",
               write_source_sel, write_awaited);
    end
    px(32'd100, 32'd200, 9'h123, 1'b0);
    px(32'd639, 32'd479, 9'h0F0, 1'b0);
    end_source();
    n_cmp++;
    if (round_busy !== 1'b0 || write_awaited !== 1'b0) begin
      n_bad++;
      $display("FAIL round_done: busy=%b aw=%b want 0 0",
               round_busy, write_awaited);
    end
  endtask

  task automatic test_ignored();
    write_active      = 1'b1;
    write_x_addr      = 32'd1;
    write_y_addr      = 32'd1;
    write_color_data  = 9'h0AA;
    write_transparent = 1'b0;
    repeat (3) tick();
    write_active = 1'b0;
    tick();
    n_cmp++;
    if (display_bank !== 1'b0 || write_awaited !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored: db=%b aw=%b want 0 0",
               display_bank, write_awaited);
    end
  endtask

  task automatic test_swap();
    frame_pulse();
    n_cmp++;
    if (display_bank !== 1'b1 || mem_bank !== 1'b0 ||
        write_source_sel !== 1'b0 || write_awaited !== 1'b1 ||
        overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL swap: db=%b mb=%b sel=%b aw=%b ov=%b",
               display_bank, mem_bank, write_source_sel, write_awaited,
               overrun);
    end
  endtask

  task automatic test_overrun();
    px(32'd2, 32'd2, 9'h101, 1'b0);
    end_source();
    px(32'd3, 32'd3, 9'h102, 1'b0);
    frame = 1'b1;
    px(32'd4, 32'd4, 9'h103, 1'b0);
    frame = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1 || display_bank !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_pulse: ov=%b db=%b want 1 1",
               overrun, display_bank);
    end
    px(32'd5, 32'd5, 9'h104, 1'b0);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_width: ov=%b want 0", overrun);
    end
    end_source();
    n_cmp++;
    if (round_busy !== 1'b0 || display_bank !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_noswap: busy=%b db=%b want 0 1",
               round_busy, display_bank);
    end
    frame_pulse();
    n_cmp++;
    if (display_bank !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_late_swap: db=%b ov=%b want 0 0",
               display_bank, overrun);
    end
  endtask

  task automatic test_frame_at_next();
    px(32'd0, 32'd0, 9'h000, 1'b1);
    end_source();
    px(32'd0, 32'd0, 9'h000, 1'b1);
    write_active = 1'b0;
    tick();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1 || round_busy !== 1'b0 || display_bank !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_at_next: ov=%b busy=%b db=%b want 1 0 0",
               overrun, round_busy, display_bank);
    end
    tick();
    frame_pulse();
    n_cmp++;
    if (display_bank !== 1'b1 || write_awaited !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_at_next_swap: db=%b aw=%b want 1 1",
               display_bank, write_awaited);
    end
  endtask

`ifdef WRITE_TIMEOUT_EN
  task automatic test_timeout();
    write_active = 1'b0;
    repeat (7) tick();
    n_cmp++;
    if (timeout !== 1'b0 || write_awaited !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_early: to=%b aw=%b want 0 1",
               timeout, write_awaited);
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b1 || write_awaited !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_fire: to=%b aw=%b want 1 0",
               timeout, write_awaited);
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b0 || write_source_sel !== 1'b1 ||
        write_awaited !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_skip: to=%b sel=%b aw=%b want 0 1 1",
               timeout, write_source_sel, write_awaited);
    end
  endtask
`endif

  task automatic test_reset_mid_round();
    px(32'd7, 32'd9, 9'h0F0, 1'b0);
    reset             = 1'b1;
    write_active      = 1'b1;
    write_x_addr      = 32'd8;
    write_y_addr      = 32'd9;
    write_transparent = 1'b0;
    tick();
    n_cmp++;
    if (mem_we !== 1'b0 || write_awaited !== 1'b0 || round_busy !== 1'b0 ||
        display_bank !== 1'b0 || write_source_sel !== 1'b0 ||
        mem_addr !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_mid: we=%b aw=%b busy=%b db=%b sel=%b addr=%0d",
               mem_we, write_awaited, round_busy, display_bank,
               write_source_sel, mem_addr);
    end
    reset        = 1'b0;
    write_active = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset             = 1'b1;
    frame             = 1'b0;
    write_active      = 1'b0;
    write_x_addr      = '0;
    write_y_addr      = '0;
    write_color_data  = '0;
    write_transparent = 1'b0;
    test_reset();
    test_first_frame();
    test_pixels();
    test_drops();
    test_round_end();
    test_ignored();
    test_swap();
    test_overrun();
    test_frame_at_next();
`ifdef WRITE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_round();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_writes: pending=%0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
